// File: rtl/ofifo_drain_pkg.sv
// Shared definitions for the output-FIFO drain path: state encoding and the
// default psum lane width / column count also used by the FIFO and SRAM wrapper.
package ofifo_drain_pkg;

    localparam int BW_DEF     = 16;
    localparam int COL_DEF    = 8;
    localparam int ADDR_W_DEF = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DRAIN = ST_DRAIN,
        S_FLUSH = ST_FLUSH,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/ofifo_drain_psum_relu_lane.sv
// Per-lane ReLU clamp for one signed psum lane; purely combinational.
module psum_relu_lane #(
    parameter int BW = 16
) (
    input  logic [BW-1:0] i_d,
    output logic [BW-1:0] o_q
);

    assign o_q = i_d[BW-1] ? '0 : i_d;

endmodule

// File: rtl/ofifo_drain.sv
// Output-FIFO read-side controller: pops a programmed number of words and writes
// them to consecutive psum SRAM addresses. Optional lane ReLU via OFIFO_DRAIN_RELU_EN.
module ofifo_drain
    import ofifo_drain_pkg::*;
#(
    parameter int BW     = BW_DEF,
    parameter int COL    = COL_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [ADDR_W:0]     i_num_words,
    input  logic [COL*BW-1:0]   i_fifo_out,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd,
    output logic                o_mem_cen,
    output logic                o_mem_wen,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [COL*BW-1:0]   o_mem_d,
    output logic                o_busy,
    output logic                o_done
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [COL*BW-1:0]   r_wdata;
    logic                r_wvalid;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [COL*BW-1:0]   r_last_d;
    logic [COL*BW-1:0]   w_lane_q;
    logic                w_pop;

`ifdef OFIFO_DRAIN_RELU_EN
    for (genvar g = 0; g < COL; g++) begin : g_lane
        psum_relu_lane #(.BW(BW)) u_lane (
            .i_d (i_fifo_out[g*BW +: BW]),
            .o_q (w_lane_q[g*BW +: BW])
        );
    end
`else
    assign w_lane_q = i_fifo_out;
`endif

    assign w_pop = (r_state == S_DRAIN) && !i_fifo_empty;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = (i_num_words == '0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (w_pop && r_remaining == (ADDR_W+1)'(1)) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_wr_addr   <= '0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_last_addr <= '0;
            r_last_d    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wvalid <= w_pop;
            // Remember the last write so the SRAM bus holds steady between writes.
            if (r_wvalid) begin
                r_wr_addr   <= r_wr_addr + ADDR_W'(1);
                r_last_addr <= r_wr_addr;
                r_last_d    <= r_wdata;
            end
            if (w_pop) begin
                r_wdata     <= w_lane_q;
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
            // No write is in flight in IDLE, so loading wr_addr here cannot collide.
            if (r_state == S_IDLE && i_start) begin
                r_wr_addr   <= i_base_addr;
                r_remaining <= i_num_words;
            end
        end
    end

    assign o_fifo_rd  = w_pop;
    assign o_mem_cen  = ~r_wvalid;
    assign o_mem_wen  = ~r_wvalid;
    assign o_mem_addr = r_wvalid ? r_wr_addr : r_last_addr;
    assign o_mem_d    = r_wvalid ? r_wdata   : r_last_d;
    assign o_busy     = (r_state == S_DRAIN) || (r_state == S_FLUSH);
    assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_ofifo_drain.sv
// Self-checking bench for ofifo_drain: behavioural FIFO, write scoreboard and
// expected SRAM writes derived from the drain rules.
module tb_ofifo_drain;

    localparam int BW  = 16;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int DW  = COL*BW;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic [DW-1:0] fifo_out;
    logic          fifo_empty, fifo_rd, mem_cen, mem_wen, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;

    always #5 clk = ~clk;

    ofifo_drain dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr),
        .i_num_words(num_words), .i_fifo_out(fifo_out), .i_fifo_empty(fifo_empty),
        .o_fifo_rd(fifo_rd), .o_mem_cen(mem_cen), .o_mem_wen(mem_wen),
        .o_mem_addr(mem_addr), .o_mem_d(mem_d), .o_busy(busy), .o_done(done)
    );

    // Behavioural 64-deep FIFO; stall_hide masks data to create empty cycles.
    logic [DW-1:0] fmem [0:63];
    logic [5:0]    frp = '0, fwp = '0;
    int            fcnt = 0, pops = 0, cyc = 0, stall_mode = 0;
    logic          stall_hide = 1'b0, force_empty = 1'b0, push_en = 1'b0;
    logic [DW-1:0] push_d = '0;

    assign fifo_out   = fmem[frp];
    assign fifo_empty = (fcnt == 0) || stall_hide || force_empty;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd && !fifo_empty) begin
            frp  <= frp + 6'd1;
            pops <= pops + 1;
        end
        if (push_en) begin
            fmem[fwp] <= push_d;
            fwp       <= fwp + 6'd1;
        end
        fcnt <= fcnt + (push_en ? 1 : 0) - ((fifo_rd && !fifo_empty) ? 1 : 0);
        case (stall_mode)
            1:       stall_hide <= ($urandom_range(0, 2) == 0);
            2:       stall_hide <= ((cyc % 3) != 0);
            default: stall_hide <= 1'b0;
        endcase
    end

    // Monitor: every SRAM write, done pulse, pop request, and pop-while-empty.
    logic [AW+DW:0] wq [$];
    int done_cnt = 0, done_cyc = 0, rd_cnt = 0, viol = 0;

    always @(negedge clk) begin
        if (mem_cen === 1'b0) wq.push_back({mem_wen, mem_addr, mem_d});
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (fifo_rd === 1'b1) rd_cnt = rd_cnt + 1;
        if (fifo_rd === 1'b1 && fifo_empty === 1'b1) viol = viol + 1;
    end

    logic [DW-1:0] mq [$];
    int ntests = 0, nfail = 0;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = w;
`ifdef OFIFO_DRAIN_RELU_EN
        for (int l = 0; l < COL; l++)
            if ($signed(w[l*BW +: BW]) < 0) r[l*BW +: BW] = '0;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        push_en = 1'b1;
        push_d  = w;
        mq.push_back(w);
        step();
        push_en = 1'b0;
    endtask

    task automatic check_writes(input logic [AW-1:0] b, input int n, input int w0, input bit hold);
        logic [DW-1:0] dummy;
        chk("wr_cnt", wq.size() - w0, n);
        for (int i = 0; i < n && (w0 + i) < wq.size(); i++)
            chk("write", wq[w0+i], {1'b0, AW'(b + i), relu(mq[i])});
        if (hold && n > 0) begin
            chk("hold_addr", mem_addr, AW'(b + n - 1));
            chk("hold_d", mem_d, relu(mq[n-1]));
            chk("hold_cen", mem_cen, 1'b1);
        end
        for (int i = 0; i < n; i++) dummy = mq.pop_front();
    endtask

    task automatic run(input logic [AW-1:0] b, input int n, input int smode,
                       input bit chk_lat, input bit restart);
        int d0, r0, v0, w0, s, k;
        d0 = done_cnt; r0 = rd_cnt; v0 = viol; w0 = wq.size();
        stall_mode = smode;
        base_addr  = b;
        num_words  = (AW+1)'(n);
        start      = 1'b1;
        s          = cyc;
        step();
        start = 1'b0;
        if (restart) begin
            repeat (3) step();
            chk("busy_mid", busy, 1'b1);
            base_addr = b + AW'(5);
            num_words = 3;
            start     = 1'b1;
            step();
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == d0 && k < 2000) begin
            step();
            k++;
        end
        repeat (3) step();
        stall_mode = 0;
        chk("done_cnt", done_cnt - d0, 1);
        if (chk_lat) chk("latency", done_cyc - s, (n == 0) ? 1 : n + 2);
        chk("rd_cnt", rd_cnt - r0, n);
        chk("pop_empty", viol - v0, 0);
        chk("busy_end", busy, 1'b0);
        check_writes(b, n, w0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] w;
        int p0, w0, k, n;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        repeat (2) step();
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_cen", mem_cen, 1'b1);
        chk("rst_wen", mem_wen, 1'b1);
        chk("rst_addr", mem_addr, '0);
        chk("rst_d", mem_d, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        step();

        for (int i = 1; i <= 8; i++) push({COL{16'(i)}});
        run(11'h010, 8, 0, 1'b1, 1'b0);

        push({$urandom, $urandom, $urandom, $urandom});
        push({$urandom, $urandom, $urandom, $urandom});
        run(11'h055, 0, 0, 1'b1, 1'b0);
        chk("zero_keep", fcnt, 2);
        run(11'h200, 2, 0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) push({$urandom, $urandom, $urandom, $urandom});
        run(11'h030, 4, 2, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) push({$urandom, $urandom, $urandom, $urandom});
        run(11'h040, 6, 0, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) push({$urandom, $urandom, $urandom, $urandom});
        run(11'h7FE, 4, 0, 1'b1, 1'b0);

        // Reset after 3 of 10 pops; hide the FIFO so no 4th pop lands on the reset edge.
        for (int i = 0; i < 10; i++) push({$urandom, $urandom, $urandom, $urandom});
        w0 = wq.size(); p0 = pops;
        base_addr = 11'h100; num_words = 10; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (pops - p0 < 3 && k < 100) begin
            step();
            k++;
        end
        force_empty = 1'b1;
        reset       = 1'b1;
        step();
        chk("mid_fifo_rd", fifo_rd, 1'b0);
        chk("mid_cen", mem_cen, 1'b1);
        chk("mid_wen", mem_wen, 1'b1);
        chk("mid_addr", mem_addr, '0);
        chk("mid_d", mem_d, '0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        reset       = 1'b0;
        force_empty = 1'b0;
        step();
        chk("fifo_keep", fcnt, 7);
        check_writes(11'h100, 3, w0, 1'b0);
        run(11'h3C0, 7, 0, 1'b1, 1'b0);

        w = {$urandom, $urandom, 16'h8000, 16'h0007, 16'h0000, 16'hFFFB};
        push(w);
        run(11'h020, 1, 0, 1'b1, 1'b0);
`ifdef OFIFO_DRAIN_RELU_EN
        chk("relu_lanes", mem_d[63:0], 64'h0000_0007_0000_0000);
`else
        chk("relu_lanes", mem_d[63:0], 64'h8000_0007_0000_FFFB);
`endif

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) push({$urandom, $urandom, $urandom, $urandom});
            run(AW'($urandom_range(0, 2047)), n, 1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/ofifo_drain.md
# ofifo_drain

Read-side controller for the 64-deep output FIFO that collects per-column partial sums. On a start pulse it pops a programmed number of words from the FIFO, one per cycle whenever the FIFO is non-empty. Each popped word goes through an optional lane-wise ReLU. The result is written into the psum SRAM at consecutive addresses from a programmed base. It sits between the output FIFO and the psum SRAM, under control of the core FSM.

## Interface
- `bw`, 16, bit width of one psum lane (signed two's complement)
- `col`, 8, lanes per FIFO word; word width is `col*bw`
- `addr_w`, 11, SRAM address width
- `clk`  in  1  single clock for the whole block
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a drain; sampled only in IDLE
- `base_addr`  in  addr_w  first SRAM address; sampled with `start`
- `num_words`  in  addr_w+1  words to drain, 0..2^addr_w; sampled with `start`
- `fifo_out`  in  col*bw  FIFO read data; combinational from the FIFO read pointer
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd`  out  1  pop request to the FIFO
- `mem_cen`  out  1  SRAM chip enable, active-low
- `mem_wen`  out  1  SRAM write enable, active-low
- `mem_addr`  out  addr_w  SRAM address
- `mem_d`  out  col*bw  SRAM write data
- `busy`  out  1  high from the cycle after `start` is accepted through FLUSH
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAIN, FLUSH, DONE.
- IDLE → DRAIN on `start` with `num_words`≠0. `base_addr` and `num_words` are latched into `wr_addr` and `remaining`.
- IDLE → DONE on `start` with `num_words`=0. No pop and no write occur.
- `fifo_rd` = (state==DRAIN) && !`fifo_empty`. It is combinational, with no registered lag.
- On each pop cycle:
  - `fifo_out` (after ReLU if enabled) is captured into `wdata_q` and `wvalid_q` is set.
  - `remaining` decrements.
- While `wvalid_q`=1: `mem_cen`=0, `mem_wen`=0, `mem_addr`=`wr_addr`, `mem_d`=`wdata_q`. `wr_addr` then increments modulo 2^addr_w and `wvalid_q` clears unless a new pop occurs in the same cycle.
- DRAIN with `fifo_empty`=1: stall. No pop, `remaining` holds, and no write occurs on the following cycle.
- DRAIN → FLUSH on the pop with `remaining`==1. FLUSH issues the final write; FLUSH → DONE.
- DONE: `done`=1 for exactly one cycle; DONE → IDLE.
- `start` outside IDLE is ignored; no queuing.
- Address wrap: `wr_addr` 2^addr_w−1 → 0 silently.
- Reset, including mid-drain:
  - state=IDLE; `remaining`, `wr_addr`, `wdata_q` and `wvalid_q` cleared.
  - An in-flight captured word is discarded and unread FIFO contents are left untouched.
- Reset values: `fifo_rd`=0, `mem_cen`=1, `mem_wen`=1, `mem_addr`=0, `mem_d`=0, `busy`=0, `done`=0.
- When not writing: `mem_cen`=`mem_wen`=1; `mem_addr` and `mem_d` hold their last values.

## Timing
- `start` accepted at cycle t. First possible pop at t+1; its SRAM write at t+2, address `base_addr`.
- Sustained throughput is 1 word/cycle while the FIFO is non-empty.
- Pop→write latency is 1 cycle.
- Last pop at cycle k: FLUSH write at k+1, `done` at k+2, IDLE at k+3.
- Zero-length request: `start` at t → `done` at t+1.
- `busy` = state ∈ {DRAIN, FLUSH}.

## Configuration
- `OFIFO_DRAIN_RELU_EN` defined: each `bw`-bit lane of `fifo_out` is forced to 0 if its MSB is 1, before capture. Applied independently per lane; no added latency.
- Undefined: data passes unmodified. Timing is identical in both builds.

## Structure
- Shared package holds:
  - the state encoding localparams (IDLE=0, DRAIN=1, FLUSH=2, DONE=3);
  - the default lane width and column count, shared with the FIFO and the SRAM wrapper.
- One sub-module, `psum_relu_lane`: a per-lane clamp, instantiated `col` times under `OFIFO_DRAIN_RELU_EN`.
- Everything else is one always block for the FSM/counters plus output assigns.

## Test plan
- Basic drain: FIFO preloaded with 8 words 0x…01..0x…08, `base_addr`=0x010, `num_words`=8 → writes at 0x010..0x017 in order on 8 consecutive cycles, `done` 2 cycles after the 8th pop.
- Stall: FIFO fed 1 word every 3 cycles, `num_words`=4 → exactly 4 writes, with gaps where `mem_cen`=1; no pop while `fifo_empty`=1; `done` after the 4th write.
- Zero length and ignored start: `num_words`=0 → `done` the next cycle, no `fifo_rd`. Also `start` re-pulsed mid-drain → ignored, total write count unchanged.
- Wrap: `base_addr`=0x7FE, `num_words`=4 (addr_w=11) → addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Reset mid-drain: `reset` asserted after 3 of 10 pops → next cycle all outputs at reset values; FIFO retains 7 words; a new start with `num_words`=7 drains them correctly.
- ReLU build: lane values −5, 0, 7, 0x8000 → written as 0, 0, 7, 0. Non-ReLU build writes them unchanged.
